// File: rtl/branch_resolve_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_pkg
// Brief    : Shared constants and types for the EX-stage branch resolver:
//            branch funct3 encodings, redirect FSM states, default PC width.
// Revision : 1.0 - initial release
// ============================================================================
package branch_resolve_pkg;

    localparam int PC_W_DEFAULT = 32;

    // Conditional-branch condition codes (funct3 field)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Redirect handshake state
    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } redir_state_e;

endpackage : branch_resolve_pkg
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond
// Brief    : Maps funct3 plus comparator flags to a taken decision; flags the
//            two reserved encodings (010/011) as illegal, never taken.
// Revision : 1.0 - initial release
// ============================================================================
module branch_cond
    import branch_resolve_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_less_s,
    input  logic       i_less_u,
    input  logic       i_equal,
    output logic       o_taken,
    output logic       o_illegal
);

    // Condition decode; anything not a defined branch code is illegal
    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_taken = i_equal;
            F3_BNE:  o_taken = ~i_equal;
            F3_BLT:  o_taken = i_less_s;
            F3_BGE:  o_taken = ~i_less_s;
            F3_BLTU: o_taken = i_less_u;
            F3_BGEU: o_taken = ~i_less_u;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule : branch_cond
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve
// Brief    : EX-stage control-flow resolution. Computes actual outcome and
//            target of branches/jumps, detects mispredicts, and issues a
//            registered redirect to fetch over a valid/ready handshake while
//            flushing IF/ID and ignoring wrong-path instructions.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int PC_W  = PC_W_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_br,
    input  logic             i_ex_is_jal,
    input  logic             i_ex_is_jalr,
    input  logic [2:0]       i_ex_funct3,
    input  logic [PC_W-1:0]  i_ex_pc,
    input  logic [PC_W-1:0]  i_ex_imm,
    input  logic [PC_W-1:0]  i_ex_rs1,
    input  logic             i_ex_pred_taken,
    input  logic [PC_W-1:0]  i_ex_pred_target,
    input  logic             i_less_s,
    input  logic             i_less_u,
    input  logic             i_equal,
    output logic             o_br_taken,
    output logic [PC_W-1:0]  o_link_pc,
    output logic             o_flush_if_id,
    output logic             o_redirect_valid,
    output logic [PC_W-1:0]  o_redirect_pc,
    input  logic             i_redirect_ready,
    output logic             o_illegal_br,
    output logic [CNT_W-1:0] o_cnt_branch,
    output logic [CNT_W-1:0] o_cnt_mispred
);

    redir_state_e     r_state;
    redir_state_e     w_state_nxt;
    logic             w_flush;
    logic             w_cond;
    logic             w_cond_illegal;
    logic             w_resolve;
    logic             w_taken;
    logic             w_mispred;
    logic [PC_W-1:0]  w_br_target;
    logic [PC_W-1:0]  w_jalr_sum;
    logic [PC_W-1:0]  w_target;
    logic [PC_W-1:0]  w_link;
    logic [PC_W-1:0]  w_actual_next;
    logic [PC_W-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_cnt_branch;
    logic [CNT_W-1:0] r_cnt_mispred;

    branch_cond u_branch_cond (
        .i_funct3  (i_ex_funct3),
        .i_less_s  (i_less_s),
        .i_less_u  (i_less_u),
        .i_equal   (i_equal),
        .o_taken   (w_cond),
        .o_illegal (w_cond_illegal)
    );

    // Only instructions arriving while no redirect is outstanding are real;
    // everything seen during REDIRECT is wrong-path.
    assign w_resolve = i_ex_valid & (i_ex_is_br | i_ex_is_jal | i_ex_is_jalr)
                     & (r_state == IDLE);
    assign w_taken   = i_ex_is_jal | i_ex_is_jalr | (i_ex_is_br & w_cond);

    // Target adders wrap modulo 2^PC_W; JALR clears bit 0
    assign w_br_target   = i_ex_pc + i_ex_imm;
    assign w_jalr_sum    = i_ex_rs1 + i_ex_imm;
    assign w_target      = i_ex_is_jalr ? {w_jalr_sum[PC_W-1:1], 1'b0} : w_br_target;
    assign w_link        = i_ex_pc + PC_W'(4);
    assign w_actual_next = w_taken ? w_target : w_link;

    // A taken prediction is wrong if either direction or target differs
    assign w_mispred = w_resolve & ((i_ex_pred_taken != w_taken)
                     | (w_taken & (i_ex_pred_target != w_target)));

    // Redirect state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and flush: flush on the mispredict cycle and for the
    // whole redirect window, including the accept cycle
    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mispred) begin
                    w_flush     = 1'b1;
                    w_state_nxt = REDIRECT;
                end
            end
            REDIRECT: begin
                w_flush = 1'b1;
                if (i_redirect_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Corrected PC is captured once and held until fetch accepts it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       r_redirect_pc <= '0;
        else if (w_mispred) r_redirect_pc <= w_actual_next;
    end

    // Saturating performance counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt_branch  <= '0;
            r_cnt_mispred <= '0;
        end else begin
            if (w_resolve && (r_cnt_branch != '1))  r_cnt_branch  <= r_cnt_branch + CNT_W'(1);
            if (w_mispred && (r_cnt_mispred != '1)) r_cnt_mispred <= r_cnt_mispred + CNT_W'(1);
        end
    end

    // Combinational outputs are forced low while reset is asserted
    assign o_br_taken       = i_rst_n & w_resolve & w_taken;
    assign o_illegal_br     = i_rst_n & w_resolve & i_ex_is_br & w_cond_illegal;
    assign o_link_pc        = i_rst_n ? w_link : '0;
    assign o_flush_if_id    = i_rst_n & w_flush;
    assign o_redirect_valid = (r_state == REDIRECT);
    assign o_redirect_pc    = r_redirect_pc;
    assign o_cnt_branch     = r_cnt_branch;
    assign o_cnt_mispred    = r_cnt_mispred;

endmodule : branch_resolve
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve
// Brief    : Self-checking bench for branch_resolve: directed scenarios plus a
//            randomized run against an operand-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;

    localparam int PW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ex_valid = 1'b0, is_br = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
    logic [2:0]    f3 = '0;
    logic [PW-1:0] pc = '0, imm = '0, rs1 = '0, ptgt = '0;
    logic          pt = 1'b0, less_s = 1'b0, less_u = 1'b0, equal = 1'b0, ready = 1'b0;
    logic          br_taken, flush, rv, illegal;
    logic [PW-1:0] link_pc, rpc;
    logic [CW-1:0] cnt_b, cnt_m;

    int errors = 0;
    int checks = 0;

    // op index: 0 BEQ 1 BNE 2 BLT 3 BGE 4 BLTU 5 BGEU 6 JAL 7 JALR 8/9 reserved 10 non-control
    logic [2:0] f3_tab [0:10] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd0, 3'd2, 3'd3, 3'd0};

    always #5 clk = ~clk;

    branch_resolve #(.PC_W(PW), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ex_valid(ex_valid), .i_ex_is_br(is_br),
        .i_ex_is_jal(is_jal), .i_ex_is_jalr(is_jalr), .i_ex_funct3(f3), .i_ex_pc(pc),
        .i_ex_imm(imm), .i_ex_rs1(rs1), .i_ex_pred_taken(pt), .i_ex_pred_target(ptgt),
        .i_less_s(less_s), .i_less_u(less_u), .i_equal(equal), .o_br_taken(br_taken),
        .o_link_pc(link_pc), .o_flush_if_id(flush), .o_redirect_valid(rv),
        .o_redirect_pc(rpc), .i_redirect_ready(ready), .o_illegal_br(illegal),
        .o_cnt_branch(cnt_b), .o_cnt_mispred(cnt_m)
    );

    // Reference semantics expressed on the operands themselves
    function automatic bit ref_taken(input int op, input logic [PW-1:0] a, input logic [PW-1:0] b);
        case (op)
            0: return a == b;
            1: return a != b;
            2: return $signed(a) <  $signed(b);
            3: return $signed(a) >= $signed(b);
            4: return a <  b;
            5: return a >= b;
            6, 7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [PW-1:0] ref_target(input int op, input logic [PW-1:0] p,
                                                 input logic [PW-1:0] im, input logic [PW-1:0] r1);
        logic [PW-1:0] s;
        if (op == 7) begin
            s = r1 + im;
            s[0] = 1'b0;
            return s;
        end
        return p + im;
    endfunction

    // Present one EX instruction; flags derived from operands a and b
    task automatic set_ex(input bit v, input int op, input logic [PW-1:0] p, input logic [PW-1:0] im,
                          input logic [PW-1:0] r1, input bit ptk, input logic [PW-1:0] pg,
                          input logic [PW-1:0] a, input logic [PW-1:0] b);
        ex_valid = v;
        is_br    = (op <= 5) || (op == 8) || (op == 9);
        is_jal   = (op == 6);
        is_jalr  = (op == 7);
        f3       = f3_tab[op];
        pc = p; imm = im; rs1 = r1; pt = ptk; ptgt = pg;
        less_s = ($signed(a) < $signed(b));
        less_u = (a < b);
        equal  = (a == b);
    endtask

    task automatic do_reset();
        set_ex(1'b0, 10, '0, '0, '0, 1'b0, '0, '0, '0);
        ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_ex(1'b1, 2, 32'h100, 32'h20, '0, 1'b0, '0, 32'd1, 32'd2);
        #1;
        checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got=%b exp=0", br_taken); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
        checks++; if (link_pc !== '0) begin errors++; $display("FAIL reset_link got=%h exp=0", link_pc); end
        @(posedge clk); #1;
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL reset_rv got=%b exp=0", rv); end
        checks++; if (rpc !== '0) begin errors++; $display("FAIL reset_rpc got=%h exp=0", rpc); end
        checks++; if (cnt_b !== '0 || cnt_m !== '0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt_b, cnt_m); end
        do_reset();
    endtask

    task automatic test_blt_mispredict();
        do_reset();
        set_ex(1'b1, 2, 32'h100, 32'h20, '0, 1'b0, '0, 32'hFFFF_FFFF, 32'd1);
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL blt_flush got=%b exp=1", flush); end
        checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL blt_taken got=%b exp=1", br_taken); end
        @(posedge clk); #1;
        set_ex(1'b0, 10, '0, '0, '0, 1'b0, '0, '0, '0);
        ready = 1'b1;
        #1;
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL blt_rv got=%b exp=1", rv); end
        checks++; if (rpc !== 32'h120) begin errors++; $display("FAIL blt_rpc got=%h exp=120", rpc); end
        checks++; if (cnt_b !== 4'd1 || cnt_m !== 4'd1) begin errors++; $display("FAIL blt_cnt got=%0d/%0d exp=1/1", cnt_b, cnt_m); end
        @(posedge clk); #1;
        ready = 1'b0;
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL blt_release got=%b exp=0", rv); end
    endtask

    task automatic test_bgeu_not_taken();
        do_reset();
        set_ex(1'b1, 5, 32'h200, 32'h40, '0, 1'b0, '0, 32'd1, 32'd2);
        #1;
        checks++; if (flush !== 1'b0 || br_taken !== 1'b0) begin errors++; $display("FAIL bgeu_flush_taken got=%b/%b exp=0/0", flush, br_taken); end
        checks++; if (link_pc !== 32'h204) begin errors++; $display("FAIL bgeu_link got=%h exp=204", link_pc); end
        @(posedge clk); #1;
        set_ex(1'b0, 10, '0, '0, '0, 1'b0, '0, '0, '0);
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL bgeu_rv got=%b exp=0", rv); end
        checks++; if (cnt_b !== 4'd1 || cnt_m !== 4'd0) begin errors++; $display("FAIL bgeu_cnt got=%0d/%0d exp=1/0", cnt_b, cnt_m); end
    endtask

    task automatic test_jalr();
        do_reset();
        set_ex(1'b1, 7, 32'h40, 32'h4, 32'h1003, 1'b1, 32'h1006, '0, '0);
        #1;
        checks++; if (flush !== 1'b0 || br_taken !== 1'b1) begin errors++; $display("FAIL jalr_ok got=%b/%b exp=0/1", flush, br_taken); end
        @(posedge clk); #1;
        set_ex(1'b1, 7, 32'h40, 32'h4, 32'h1003, 1'b1, 32'h1000, '0, '0);
        #1;
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL jalr_ok_rv got=%b exp=0", rv); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jalr_bad_flush got=%b exp=1", flush); end
        @(posedge clk); #1;
        set_ex(1'b0, 10, '0, '0, '0, 1'b0, '0, '0, '0);
        ready = 1'b1;
        #1;
        checks++; if (rv !== 1'b1 || rpc !== 32'h1006) begin errors++; $display("FAIL jalr_rpc got=%b/%h exp=1/1006", rv, rpc); end
        checks++; if (cnt_b !== 4'd2 || cnt_m !== 4'd1) begin errors++; $display("FAIL jalr_cnt got=%0d/%0d exp=2/1", cnt_b, cnt_m); end
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    task automatic test_back_to_back_backpressure();
        int nflush = 0;
        do_reset();
        ready = 1'b0;
        set_ex(1'b1, 0, 32'h300, 32'h40, '0, 1'b0, '0, 32'd5, 32'd5);
        #1;
        if (flush === 1'b1) nflush++;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            // wrong-path instructions that would otherwise mispredict
            if (k == 1) set_ex(1'b1, 8, 32'h500 + k, 32'h8, '0, 1'b1, '0, 32'd1, 32'd2);
            else        set_ex(1'b1, 2, 32'h500 + k, 32'h8, '0, 1'b0, '0, 32'd1, 32'd2);
            ready = (k == 2);
            #1;
            if (flush === 1'b1) nflush++;
            checks++; if (rv !== 1'b1 || rpc !== 32'h340) begin errors++; $display("FAIL bp_hold k=%0d got=%b/%h exp=1/340", k, rv, rpc); end
            checks++; if (br_taken !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL bp_wrongpath k=%0d got=%b/%b exp=0/0", k, br_taken, illegal); end
            checks++; if (cnt_b !== 4'd1 || cnt_m !== 4'd1) begin errors++; $display("FAIL bp_cnt k=%0d got=%0d/%0d exp=1/1", k, cnt_b, cnt_m); end
            @(posedge clk); #1;
        end
        set_ex(1'b0, 10, '0, '0, '0, 1'b0, '0, '0, '0);
        ready = 1'b0;
        #1;
        checks++; if (rv !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL bp_release got=%b/%b exp=0/0", rv, flush); end
        checks++; if (nflush !== 4) begin errors++; $display("FAIL bp_flush_cycles got=%0d exp=4", nflush); end
        checks++; if (cnt_b !== 4'd1 || cnt_m !== 4'd1) begin errors++; $display("FAIL bp_cnt_after got=%0d/%0d exp=1/1", cnt_b, cnt_m); end
    endtask

    task automatic test_reset_mid_redirect();
        do_reset();
        set_ex(1'b1, 6, 32'h80, 32'h100, '0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        set_ex(1'b0, 10, '0, '0, '0, 1'b0, '0, '0, '0);
        #1;
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b exp=1", rv); end
        rst_n = 1'b0;
        #1;
        checks++; if (rv !== 1'b0 || rpc !== '0) begin errors++; $display("FAIL midrst_async got=%b/%h exp=0/0", rv, rpc); end
        checks++; if (cnt_b !== '0 || cnt_m !== '0 || flush !== 1'b0) begin errors++; $display("FAIL midrst_cnt got=%0d/%0d/%b exp=0/0/0", cnt_b, cnt_m, flush); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL midrst_idle got=%b exp=0", rv); end
    endtask

    task automatic test_illegal();
        do_reset();
        set_ex(1'b1, 8, 32'h600, 32'h10, '0, 1'b0, '0, 32'd3, 32'd3);
        #1;
        checks++; if (illegal !== 1'b1 || br_taken !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL ill010 got=%b/%b/%b exp=1/0/0", illegal, br_taken, flush); end
        @(posedge clk); #1;
        set_ex(1'b1, 9, 32'h700, 32'h10, '0, 1'b1, 32'h710, 32'd3, 32'd3);
        #1;
        checks++; if (illegal !== 1'b1 || flush !== 1'b1) begin errors++; $display("FAIL ill011 got=%b/%b exp=1/1", illegal, flush); end
        @(posedge clk); #1;
        set_ex(1'b0, 8, '0, '0, '0, 1'b0, '0, '0, '0);
        ready = 1'b1;
        #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_novalid got=%b exp=0", illegal); end
        checks++; if (rpc !== 32'h704 || cnt_b !== 4'd2 || cnt_m !== 4'd1) begin errors++; $display("FAIL ill_rpc got=%h/%0d/%0d exp=704/2/1", rpc, cnt_b, cnt_m); end
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_ex(1'b1, 6, 32'(i * 16), 32'h100, '0, 1'b0, '0, '0, '0);
            @(posedge clk); #1;
            set_ex(1'b0, 10, '0, '0, '0, 1'b0, '0, '0, '0);
            @(posedge clk); #1;
            if (i == 13) begin
                checks++; if (cnt_b !== 4'hE || cnt_m !== 4'hE) begin errors++; $display("FAIL sat_pre got=%h/%h exp=E/E", cnt_b, cnt_m); end
            end
        end
        checks++; if (cnt_b !== 4'hF || cnt_m !== 4'hF) begin errors++; $display("FAIL sat_hold got=%h/%h exp=F/F", cnt_b, cnt_m); end
        set_ex(1'b1, 6, 32'h10, 32'h20, '0, 1'b1, 32'h30, '0, '0);
        @(posedge clk); #1;
        checks++; if (cnt_b !== 4'hF || cnt_m !== 4'hF || rv !== 1'b0) begin errors++; $display("FAIL sat_final got=%h/%h/%b exp=F/F/0", cnt_b, cnt_m, rv); end
        ready = 1'b0;
    endtask

    task automatic test_random();
        bit            m_busy = 1'b0;
        logic [PW-1:0] m_rpc = '0;
        int            m_cb = 0, m_cm = 0;
        int            op;
        bit            v, ptk, res, tk, mp;
        logic [PW-1:0] p, im, r1, a, b, pg, tgt, nxt;
        for (int i = 0; i < 400; i++) begin
            if (i % 80 == 0) begin
                do_reset();
                m_busy = 1'b0; m_rpc = '0; m_cb = 0; m_cm = 0;
            end
            op  = $urandom_range(0, 10);
            v   = ($urandom_range(0, 9) != 0);
            p   = {$urandom, 2'b00} >> 2 << 2;
            im  = $urandom;
            r1  = $urandom;
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            tk  = ref_taken(op, a, b);
            tgt = ref_target(op, p, im, r1);
            ptk = ($urandom_range(0, 1) == 1);
            pg  = ($urandom_range(0, 2) != 0) ? tgt : $urandom;
            set_ex(v, op, p, im, r1, ptk, pg, a, b);
            ready = ($urandom_range(0, 2) == 0);
            res = v && (op != 10) && !m_busy;
            mp  = res && ((ptk != tk) || (tk && pg != tgt));
            nxt = tk ? tgt : p + 32'd4;
            #1;
            checks++; if (br_taken !== (res && tk)) begin errors++; $display("FAIL rnd_taken i=%0d got=%b exp=%b", i, br_taken, res && tk); end
            checks++; if (illegal !== (res && (op == 8 || op == 9))) begin errors++; $display("FAIL rnd_illegal i=%0d got=%b", i, illegal); end
            checks++; if (flush !== (m_busy || mp)) begin errors++; $display("FAIL rnd_flush i=%0d got=%b exp=%b", i, flush, m_busy || mp); end
            checks++; if (link_pc !== p + 32'd4) begin errors++; $display("FAIL rnd_link i=%0d got=%h exp=%h", i, link_pc, p + 32'd4); end
            checks++; if (rv !== m_busy) begin errors++; $display("FAIL rnd_rv i=%0d got=%b exp=%b", i, rv, m_busy); end
            if (m_busy) begin
                checks++; if (rpc !== m_rpc) begin errors++; $display("FAIL rnd_rpc i=%0d got=%h exp=%h", i, rpc, m_rpc); end
            end
            checks++; if (cnt_b !== CW'(m_cb) || cnt_m !== CW'(m_cm)) begin errors++; $display("FAIL rnd_cnt i=%0d got=%0d/%0d exp=%0d/%0d", i, cnt_b, cnt_m, m_cb, m_cm); end
            @(posedge clk); #1;
            if (m_busy) begin
                if (ready) m_busy = 1'b0;
            end else if (mp) begin
                m_busy = 1'b1;
                m_rpc  = nxt;
            end
            if (res && m_cb < 15) m_cb++;
            if (mp && m_cm < 15) m_cm++;
        end
        ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_blt_mispredict();
        test_bgeu_not_taken();
        test_jalr();
        test_back_to_back_backpressure();
        test_reset_mid_redirect();
        test_illegal();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_branch_resolve
`default_nettype wire

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
EX-stage control-flow resolution unit. It sits directly downstream of the subtract-flag comparator and consumes its signed-less, unsigned-less and equal flags. It decides the real outcome of BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR, compares that outcome with the IF-stage prediction, and on a mispredict issues a registered redirect to fetch through a valid/ready handshake. Until fetch accepts the redirect, it holds a flush on IF/ID and suppresses wrong-path resolutions.

Parameters:
PC_W, 32, width of PC, immediate, rs1 and target paths
CNT_W, 32, width of the saturating performance counters

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_ex_valid  in  1  EX slot holds a live instruction
i_ex_is_br  in  1  conditional branch
i_ex_is_jal  in  1  JAL
i_ex_is_jalr  in  1  JALR
i_ex_funct3  in  3  branch condition code
i_ex_pc  in  PC_W  PC of the EX instruction
i_ex_imm  in  PC_W  sign-extended immediate
i_ex_rs1  in  PC_W  forwarded rs1 value (JALR base)
i_ex_pred_taken  in  1  IF-stage prediction: taken
i_ex_pred_target  in  PC_W  IF-stage predicted target
i_less_s  in  1  comparator: signed rs1 < rs2
i_less_u  in  1  comparator: unsigned rs1 < rs2
i_equal  in  1  comparator: rs1 == rs2
o_br_taken  out  1  combinational actual-taken for the EX instruction
o_link_pc  out  PC_W  combinational pc+4 for JAL/JALR writeback
o_flush_if_id  out  1  kill IF/ID contents this cycle
o_redirect_valid  out  1  redirect request to fetch
o_redirect_pc  out  PC_W  corrected fetch PC
i_redirect_ready  in  1  fetch accepts redirect
o_illegal_br  out  1  conditional branch with funct3 010/011
o_cnt_branch  out  CNT_W  resolved control instructions
o_cnt_mispred  out  CNT_W  mispredicts

Behaviour:
- resolve = i_ex_valid & (is_br | is_jal | is_jalr) & state==IDLE. Any is_* asserted without i_ex_valid is ignored.
- Condition by funct3:
  - 000 equal; 001 ~equal
  - 100 less_s; 101 ~less_s
  - 110 less_u; 111 ~less_u
  - 010/011: not taken, and o_illegal_br=1 combinationally (only when resolve).
- o_br_taken = is_jal | is_jalr | (is_br & cond).
- Target:
  - JAL and branch: pc+imm.
  - JALR: (rs1+imm) with bit0 cleared.
  - All adds are modulo 2^PC_W; carry-out is discarded.
- actual_next = taken ? target : pc+4. o_link_pc = pc+4, modulo 2^PC_W.
- mispred = resolve & ((pred_taken != taken) | (taken & pred_target != target)).
- FSM, 2 states:
  - IDLE: if mispred, then o_flush_if_id=1 combinationally, capture actual_next into the redirect register, go to REDIRECT.
  - REDIRECT: o_redirect_valid=1 and o_flush_if_id=1. o_redirect_pc is held stable. If i_redirect_ready=1, go to IDLE next edge.
  - No resolution happens in REDIRECT, including the accept cycle. All EX instructions in that window are wrong-path: o_br_taken and o_illegal_br are forced 0, and counters do not move.
- Latency: mispredict in EX cycle N gives o_redirect_valid at cycle N+1. Minimum redirect occupancy is 1 cycle, when ready is already high.
- Handshake: valid never drops and pc never changes before ready is seen. A ready without valid has no effect.
- Counters:
  - o_cnt_branch += 1 on resolve.
  - o_cnt_mispred += 1 on mispred.
  - Both saturate at all-ones and never wrap.
- Reset (async, any state including mid-REDIRECT):
  - state=IDLE; o_redirect_valid=0; o_redirect_pc=0; counters=0.
  - Combinational outputs follow their inputs but gate to 0 while in reset.

Decomposition:
- Shared package: funct3 constants (F3_BEQ … F3_BGEU), the redirect-state enum {IDLE, REDIRECT}, PC_W default.
- One sub-module, branch_cond: funct3 plus the three flags in, taken and illegal out, purely combinational.
- FSM, target adders and counters stay in branch_resolve.

Test Plan:
- BLT with pc=0x100, imm=0x20, less_s=1, pred_taken=0 -> flush=1 in cycle N; cycle N+1 redirect_valid=1 and redirect_pc=0x120; cnt_branch=1, cnt_mispred=1.
- BGEU with less_u=1 (not taken), pred_taken=0 -> no flush, no redirect, cnt_branch increments, cnt_mispred unchanged, o_link_pc=pc+4.
- JALR with rs1=0x1003, imm=0x4, pred_target=0x1006 -> target 0x1006, no mispredict. Repeat with pred_target=0x1000 -> redirect_pc=0x1006.
- Redirect back-pressure: ready=0 for 3 cycles while valid branches are presented in EX -> redirect_pc stable, flush held high for 4 cycles total, counters frozen; ready=1 -> IDLE on the next edge.
- Assert i_rst_n=0 mid-REDIRECT -> redirect_valid=0 immediately, counters 0, IDLE after release. Separately, funct3=010 -> o_illegal_br=1, not taken.
- Preload both counters to all-ones and resolve a mispredict -> both counters stay all-ones.
